// File: rtl/sc_fifo_if.sv
// Handshake and status bundle between a FIFO user (master) and the sc_fifo storage core (slave).
// Widths follow the data word and the occupancy field of the attached FIFO.
interface sc_fifo_if #(
  parameter int unsigned lpm_width  = 64,
  parameter int unsigned lpm_widthu = 8
);
  logic [lpm_width-1:0]  data;
  logic                  wrreq;
  logic                  rdreq;
  logic [lpm_width-1:0]  q;
  logic                  full;
  logic                  empty;
  logic [lpm_widthu-1:0] usedw;
  logic                  almost_full;
  logic                  almost_empty;

  modport master (
    output data, wrreq, rdreq,
    input  q, full, empty, usedw, almost_full, almost_empty
  );

  modport slave (
    input  data, wrreq, rdreq,
    output q, full, empty, usedw, almost_full, almost_empty
  );
endinterface

// File: rtl/sc_fifo.sv
// Single-clock FIFO core: words leave q in write order, with flags and usedw derived from a registered count.
// Show-ahead read has zero latency, normal read has one cycle; writes while full and reads while empty are dropped.
module sc_fifo #(
  parameter int unsigned lpm_width               = 64,
  parameter int unsigned lpm_numwords            = 8,
  parameter int unsigned lpm_widthu              = 8,
  parameter              lpm_showahead           = "ON",
  parameter              overflow_checking       = "ON",
  parameter              underflow_checking      = "ON",
  parameter int unsigned almost_full_value       = 7,
  parameter int unsigned almost_empty_value      = 1,
  parameter              add_ram_output_register = "OFF",
  parameter              intended_device_family  = "",
  parameter              lpm_hint                = "",
  parameter              lpm_type                = "scfifo",
  parameter              use_eab                 = "ON"
) (
  input  logic     clock,
  input  logic     aclr,
  input  logic     sclr,
  sc_fifo_if.slave fif
);
  localparam int unsigned PW = $clog2(lpm_numwords);
  localparam int unsigned CW = $clog2(lpm_numwords + 1);

  logic [lpm_width-1:0] ram [lpm_numwords];
  logic [PW-1:0]        wp;
  logic [PW-1:0]        rp;
  logic [CW-1:0]        cnt;
  logic                 clr;
  logic                 wr_ok;
  logic                 rd_ok;

  // Pointers wrap at the capacity, which need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(lpm_numwords - 1)) ? '0 : p + 1'b1;
  endfunction

  assign clr              = aclr | sclr;
  assign fif.full         = (cnt == CW'(lpm_numwords));
  assign fif.empty        = (cnt == '0);
  assign fif.usedw        = lpm_widthu'(cnt);
  assign fif.almost_full  = (32'(fif.usedw) >= almost_full_value);
  assign fif.almost_empty = (32'(fif.usedw) <  almost_empty_value);
  assign wr_ok            = fif.wrreq & ~fif.full;
  assign rd_ok            = fif.rdreq & ~fif.empty;

  always_ff @(posedge clock) begin
    if (clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_ok) wp <= next_ptr(wp);
      if (rd_ok) rp <= next_ptr(rp);
      cnt <= cnt + CW'(wr_ok) - CW'(rd_ok);
    end
  end

  // Storage is not cleared; a write racing a clear is discarded.
  always_ff @(posedge clock) begin
    if (wr_ok && !clr) ram[wp] <= fif.data;
  end

  generate
    if (lpm_showahead == "ON") begin : g_showahead
      assign fif.q = ram[rp];
    end else begin : g_normal
      logic [lpm_width-1:0] q_r;
      always_ff @(posedge clock) begin
        if (clr)        q_r <= '0;
        else if (rd_ok) q_r <= ram[rp];
      end
      assign fif.q = q_r;
    end
  endgenerate
endmodule

// File: tb/tb_sc_fifo.sv
// Directed bench for sc_fifo: a show-ahead instance (ifa) and a normal-mode instance (ifb) share one clock.
module tb_sc_fifo;
  logic clk;
  logic aclr;
  logic sclr_a;
  logic sclr_b;
  int   total;
  int   bad;

  sc_fifo_if #(.lpm_width(64), .lpm_widthu(8)) ifa ();
  sc_fifo_if #(.lpm_width(64), .lpm_widthu(8)) ifb ();

  sc_fifo #(.lpm_showahead("ON")) dut_a (
    .clock(clk), .aclr(aclr), .sclr(sclr_a), .fif(ifa.slave)
  );
  sc_fifo #(.lpm_showahead("OFF")) dut_b (
    .clock(clk), .aclr(aclr), .sclr(sclr_b), .fif(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    aclr = 1'b1;
    tick();
    tick();
    aclr = 1'b0;
    tick();
    total++; if (ifa.empty !== 1'b1) begin bad++; $display("FAIL rst_empty: got %b want 1", ifa.empty); end
    total++; if (ifa.full !== 1'b0) begin bad++; $display("FAIL rst_full: got %b want 0", ifa.full); end
    total++; if (ifa.usedw !== 8'd0) begin bad++; $display("FAIL rst_usedw: got %0d want 0", ifa.usedw); end
    total++; if (ifa.almost_empty !== 1'b1) begin bad++; $display("FAIL rst_aempty: got %b want 1", ifa.almost_empty); end
    total++; if (ifa.almost_full !== 1'b0) begin bad++; $display("FAIL rst_afull: got %b want 0", ifa.almost_full); end
    total++; if (ifb.q !== 64'd0) begin bad++; $display("FAIL rst_q_normal: got %h want 0", ifb.q); end
  endtask

  task automatic test_fill_overflow;
    for (int i = 0; i < 8; i++) begin
      ifa.wrreq = 1'b1;
      ifa.data  = 64'h10 + 64'(i);
      tick();
      total++; if (ifa.usedw !== 8'(i + 1)) begin bad++; $display("FAIL fill_usedw[%0d]: got %0d want %0d", i, ifa.usedw, i + 1); end
      total++; if (ifa.almost_full !== (i + 1 >= 7)) begin bad++; $display("FAIL fill_afull[%0d]: got %b want %b", i, ifa.almost_full, (i + 1 >= 7)); end
      total++; if (ifa.full !== (i == 7)) begin bad++; $display("FAIL fill_full[%0d]: got %b want %b", i, ifa.full, (i == 7)); end
    end
    ifa.data = 64'hFF;
    tick();
    ifa.wrreq = 1'b0;
    total++; if (ifa.usedw !== 8'd8) begin bad++; $display("FAIL ovf_usedw: got %0d want 8", ifa.usedw); end
    total++; if (ifa.full !== 1'b1) begin bad++; $display("FAIL ovf_full: got %b want 1", ifa.full); end
    total++; if (ifa.q !== 64'h10) begin bad++; $display("FAIL ovf_head: got %h want 10", ifa.q); end
  endtask

  task automatic test_drain_underflow;
    ifa.rdreq = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++; if (ifa.q !== 64'h10 + 64'(i)) begin bad++; $display("FAIL drain_q[%0d]: got %h want %h", i, ifa.q, 64'h10 + 64'(i)); end
      tick();
    end
    total++; if (ifa.empty !== 1'b1) begin bad++; $display("FAIL drain_empty: got %b want 1", ifa.empty); end
    tick();
    ifa.rdreq = 1'b0;
    total++; if (ifa.usedw !== 8'd0) begin bad++; $display("FAIL udf_usedw: got %0d want 0", ifa.usedw); end
    ifa.wrreq = 1'b1;
    ifa.data  = 64'h33;
    tick();
    ifa.wrreq = 1'b0;
    total++; if (ifa.q !== 64'h33) begin bad++; $display("FAIL udf_ptr_q: got %h want 33", ifa.q); end
    total++; if (ifa.usedw !== 8'd1) begin bad++; $display("FAIL udf_ptr_usedw: got %0d want 1", ifa.usedw); end
    ifa.rdreq = 1'b1;
    tick();
    ifa.rdreq = 1'b0;
  endtask

  task automatic test_simultaneous;
    ifa.wrreq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ifa.data = 64'h41 + 64'(i);
      tick();
    end
    ifa.rdreq = 1'b1;
    ifa.data  = 64'h44;
    total++; if (ifa.q !== 64'h41) begin bad++; $display("FAIL sim_mid_q: got %h want 41", ifa.q); end
    tick();
    ifa.wrreq = 1'b0;
    total++; if (ifa.usedw !== 8'd3) begin bad++; $display("FAIL sim_mid_usedw: got %0d want 3", ifa.usedw); end
    for (int i = 0; i < 3; i++) begin
      total++; if (ifa.q !== 64'h42 + 64'(i)) begin bad++; $display("FAIL sim_mid_order[%0d]: got %h want %h", i, ifa.q, 64'h42 + 64'(i)); end
      tick();
    end
    // both requests while empty: only the write lands
    ifa.wrreq = 1'b1;
    ifa.data  = 64'h55;
    tick();
    ifa.wrreq = 1'b0;
    ifa.rdreq = 1'b0;
    total++; if (ifa.usedw !== 8'd1) begin bad++; $display("FAIL sim_empty_usedw: got %0d want 1", ifa.usedw); end
    total++; if (ifa.q !== 64'h55) begin bad++; $display("FAIL sim_empty_q: got %h want 55", ifa.q); end
    ifa.rdreq = 1'b1;
    tick();
    ifa.rdreq = 1'b0;
    ifa.wrreq = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ifa.data = 64'h60 + 64'(i);
      tick();
    end
    ifa.rdreq = 1'b1;
    ifa.data  = 64'h99;
    tick();
    ifa.wrreq = 1'b0;
    ifa.rdreq = 1'b0;
    total++; if (ifa.usedw !== 8'd7) begin bad++; $display("FAIL sim_full_usedw: got %0d want 7", ifa.usedw); end
    ifa.rdreq = 1'b1;
    for (int i = 0; i < 7; i++) begin
      total++; if (ifa.q !== 64'h61 + 64'(i)) begin bad++; $display("FAIL sim_full_order[%0d]: got %h want %h", i, ifa.q, 64'h61 + 64'(i)); end
      tick();
    end
    ifa.rdreq = 1'b0;
    total++; if (ifa.empty !== 1'b1) begin bad++; $display("FAIL sim_full_empty: got %b want 1", ifa.empty); end
  endtask

  task automatic test_wrap;
    int next_rd;
    next_rd = 0;
    ifa.wrreq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ifa.data = 64'h80 + 64'(i);
      tick();
    end
    ifa.rdreq = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ifa.data = 64'h85 + 64'(i);
      total++; if (ifa.q !== 64'h80 + 64'(next_rd)) begin bad++; $display("FAIL wrap_q[%0d]: got %h want %h", next_rd, ifa.q, 64'h80 + 64'(next_rd)); end
      next_rd++;
      tick();
    end
    ifa.wrreq = 1'b0;
    total++; if (ifa.usedw !== 8'd5) begin bad++; $display("FAIL wrap_usedw: got %0d want 5", ifa.usedw); end
    for (int i = 0; i < 5; i++) begin
      total++; if (ifa.q !== 64'h80 + 64'(next_rd)) begin bad++; $display("FAIL wrap_tail_q[%0d]: got %h want %h", next_rd, ifa.q, 64'h80 + 64'(next_rd)); end
      next_rd++;
      tick();
    end
    ifa.rdreq = 1'b0;
    total++; if (ifa.empty !== 1'b1) begin bad++; $display("FAIL wrap_empty: got %b want 1", ifa.empty); end
  endtask

  task automatic test_normal_mode;
    ifb.wrreq = 1'b1;
    ifb.data  = 64'hA5;
    tick();
    ifb.wrreq = 1'b0;
    total++; if (ifb.q !== 64'd0) begin bad++; $display("FAIL norm_q_before: got %h want 0", ifb.q); end
    ifb.rdreq = 1'b1;
    tick();
    ifb.rdreq = 1'b0;
    total++; if (ifb.q !== 64'hA5) begin bad++; $display("FAIL norm_q: got %h want a5", ifb.q); end
    total++; if (ifb.empty !== 1'b1) begin bad++; $display("FAIL norm_empty: got %b want 1", ifb.empty); end
    tick();
    total++; if (ifb.q !== 64'hA5) begin bad++; $display("FAIL norm_q_hold: got %h want a5", ifb.q); end
    ifb.wrreq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ifb.data = 64'hB0 + 64'(i);
      tick();
    end
    total++; if (ifb.usedw !== 8'd4) begin bad++; $display("FAIL norm_usedw4: got %0d want 4", ifb.usedw); end
    sclr_b = 1'b1;
    ifb.rdreq = 1'b1;
    tick();
    sclr_b = 1'b0;
    ifb.wrreq = 1'b0;
    ifb.rdreq = 1'b0;
    total++; if (ifb.usedw !== 8'd0) begin bad++; $display("FAIL clr_usedw: got %0d want 0", ifb.usedw); end
    total++; if (ifb.empty !== 1'b1) begin bad++; $display("FAIL clr_empty: got %b want 1", ifb.empty); end
    total++; if (ifb.q !== 64'd0) begin bad++; $display("FAIL clr_q: got %h want 0", ifb.q); end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    aclr      = 1'b1;
    sclr_a    = 1'b0;
    sclr_b    = 1'b0;
    ifa.data  = '0;
    ifa.wrreq = 1'b0;
    ifa.rdreq = 1'b0;
    ifb.data  = '0;
    ifb.wrreq = 1'b0;
    ifb.rdreq = 1'b0;
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_simultaneous();
    test_wrap();
    test_normal_mode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sc_fifo.md
Name: sc_fifo

Overview:
- Single-clock, synchronous first-in-first-out queue used as the storage core behind the router's general-purpose buffer wrapper.
- Words written with wrreq leave on q in the same order.
- Provides full/empty/almost flags and an occupancy count usedw.
- Supports show-ahead (first-word-fall-through) and normal read modes, with overflow and underflow protection.

Parameters:
- lpm_width, 64: data word width in bits.
- lpm_numwords, 8: capacity in words, at least 2. Any value is legal; pointers must wrap at lpm_numwords, not at a power of two.
- lpm_widthu, 8: width of usedw. usedw = occupancy mod 2^lpm_widthu.
- lpm_showahead, "ON": "ON" = show-ahead mode; "OFF" = normal registered-read mode.
- overflow_checking, "ON": "ON" ignores a write while full. "OFF" behaves identically; the write is still ignored, so the bench never depends on it.
- underflow_checking, "ON": "ON" ignores a read while empty. "OFF" behaves identically.
- almost_full_value, 7: almost_full threshold.
- almost_empty_value, 1: almost_empty threshold.
- add_ram_output_register, intended_device_family, lpm_hint, lpm_type, use_eab: string attributes. Accepted for compatibility; no functional effect.

Ports:
- clock  in  1  sole clock, rising edge.
- aclr  in  1  reset, synchronous, active-high. Despite the name it is sampled only on clock.
- sclr  in  1  synchronous clear, active-high, same effect as aclr. Treated as 0 when left unconnected.
- data  in  lpm_width  write data.
- wrreq  in  1  write request.
- rdreq  in  1  read request. In show-ahead mode this is the acknowledge of the word currently on q.
- q  out  lpm_width  read data.
- full  out  1  occupancy == lpm_numwords.
- empty  out  1  occupancy == 0.
- usedw  out  lpm_widthu  occupancy count.
- almost_full  out  1  usedw >= almost_full_value.
- almost_empty  out  1  usedw < almost_empty_value.

Behaviour:
- Storage: lpm_numwords × lpm_width RAM, write pointer wp, read pointer rp, occupancy counter cnt (0..lpm_numwords). Full capacity is usable; no spare slot.
- Reset (aclr or sclr high at an edge): wp=rp=cnt=0 and the q register is cleared to 0.
  - Outputs after reset: empty=1, full=0, usedw=0, almost_empty=1 (when almost_empty_value>0), almost_full=0.
  - RAM contents are not cleared.
  - Reset has priority over any wrreq/rdreq in the same cycle; in-flight data is discarded.
- Flags and usedw are pure functions of cnt (registered state). They change on the edge following an accepted operation.
- Write accept: wr_ok = wrreq & ~full, using the pre-edge full. On an edge with wr_ok, RAM[wp] <= data and wp advances, wrapping lpm_numwords-1 to 0.
- Read accept: rd_ok = rdreq & ~empty, using the pre-edge empty. On an edge with rd_ok, rp advances with the same wrap rule.
- Counter: cnt <= cnt + wr_ok − rd_ok.
  - When full, a simultaneous read and write performs only the read; cnt goes to N−1.
  - When empty, a simultaneous read and write performs only the write; cnt goes to 1.
  - Otherwise both are accepted and cnt is unchanged.
- Show-ahead mode ("ON"):
  - q = RAM[rp] combinationally from registered state.
  - A word written into an empty FIFO appears on q, with empty=0, on the edge after the write; zero-latency read.
  - On an accepted read, q shows the next word after that edge.
  - q is don't-care while empty.
- Normal mode ("OFF"):
  - On an edge with rd_ok, q <= RAM[rp], so data is valid one cycle after the request.
  - Otherwise q holds its value.
- Read-during-write at the same address cannot occur: rd_ok needs cnt>0, and wp==rp with cnt>0 only when full, where writes are blocked.

Test Plan:
- Reset: hold aclr 2 cycles, then release -> empty=1, full=0, usedw=0, almost_empty=1, almost_full=0.
- Fill and overflow (defaults): write 0x10..0x17 on 8 consecutive cycles.
  - usedw steps 1..8 (in the 8-bit field); almost_full rises when usedw=7; full=1 after the 8th write.
  - A 9th write of 0xFF is ignored and usedw stays 8.
- Drain and underflow, show-ahead mode: from full, assert rdreq 8 cycles.
  - q reads 0x10..0x17 in order, each valid in the cycle rdreq is high; empty=1 afterwards.
  - An extra rdreq leaves usedw=0 and pointers unchanged.
- Simultaneous read/write:
  - At usedw=3 with wrreq=rdreq=1 -> usedw stays 3 and order is preserved.
  - When full, both high -> usedw=7, the write is dropped.
  - When empty, both high -> usedw=1.
- Pointer wrap: interleave 20 writes and reads at occupancy 5 -> output sequence equals input sequence, no loss.
- Normal mode plus mid-operation reset:
  - With lpm_showahead="OFF", write 0xA5, then rdreq -> q=0xA5 one cycle after the rdreq edge.
  - Reset while usedw=4 -> usedw=0, empty=1, q=0 on the next cycle.
